sdram_client_port: RTL

- Client-side requester for the team's 16-bit SDRAM controller.
- Accepts a valid/ready request stream from a core (SPU, DMA), queues requests in a small FIFO, and drives the controller's port.
- Controller port: edge-triggered rd/we, addr/din/wtbt, level `ready`, dout.
- Returns read data in order. Performs the same-address read bypass itself, so every controller access is guaranteed to drop `ready`.

---
 rtl/sdram_client_port.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_client_port.sv
// Client-side requester for the 16-bit SDRAM controller: queues core requests,
// issues edge-triggered rd/we strobes, returns read data in order with a same-address read bypass.
module sdram_client_port #(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = 6
) (
  input  logic        clk,
  input  logic        init,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        wr_done,
  output logic        busy,
  output logic        err_timeout,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_wtbt,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [15:0] mem_dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    RELEASE
  } state_t;

  state_t state, next_state;

  logic          q_we    [FIFO_DEPTH];
  logic [23:0]   q_addr  [FIFO_DEPTH];
  logic [15:0]   q_wdata [FIFO_DEPTH];
  logic [1:0]    q_be    [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          head_we;
  logic [23:0]   head_addr;
  logic [15:0]   head_wdata;
  logic [1:0]    head_be;

  logic          push, pop, bypass_hit, issue, timeout, complete;
  logic [GW-1:0] guard_cnt;

  logic          bypass_valid;
  logic [23:0]   bypass_addr;
  logic [15:0]   bypass_data;

  // req_ready comes from the registered count, so a full queue never accepts
  // even when the head is being popped in the same cycle.
  assign req_ready  = (count != FULL_COUNT);
  assign push       = req_valid & req_ready;
  assign busy       = (count != '0) || (state != IDLE);

  assign head_we    = q_we[rd_ptr];
  assign head_addr  = q_addr[rd_ptr];
  assign head_wdata = q_wdata[rd_ptr];
  assign head_be    = q_be[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]    <= req_we;
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
      q_be[wr_ptr]    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= next_state;
  end

  // Nothing is popped while mem_ready is low in IDLE, which covers controller startup.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    bypass_hit = 1'b0;
    issue      = 1'b0;
    timeout    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && mem_ready) begin
          pop = 1'b1;
          if (!head_we && bypass_valid && (head_addr == bypass_addr)) begin
            bypass_hit = 1'b1;
          end else begin
            issue      = 1'b1;
            next_state = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (!mem_ready) begin
          next_state = WAIT_HIGH;
        end else if (guard_cnt == GUARD_LAST) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (mem_ready) begin
          complete   = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      guard_cnt <= '0;
    end else if (issue) begin
      guard_cnt <= '0;
    end else if ((state == WAIT_LOW) && mem_ready && !timeout) begin
      guard_cnt <= guard_cnt + 1'b1;
    end
  end

  // Strobe, address and data are loaded once at issue and held until the access ends.
  always_ff @(posedge clk) begin
    if (init) begin
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_wtbt     <= '0;
      mem_rd       <= 1'b0;
      mem_we       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      wr_done      <= 1'b0;
      err_timeout  <= 1'b0;
      bypass_valid <= 1'b0;
      bypass_addr  <= '0;
      bypass_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
      if (bypass_hit) begin
        rsp_valid <= 1'b1;
        rsp_data  <= bypass_data;
      end
      if (pop && head_we) bypass_valid <= 1'b0;
      if (issue) begin
        mem_addr <= head_addr;
        mem_din  <= head_wdata;
        mem_wtbt <= head_be;
        mem_rd   <= ~head_we;
        mem_we   <= head_we;
      end
      if (timeout) begin
        err_timeout <= 1'b1;
        mem_rd      <= 1'b0;
        mem_we      <= 1'b0;
      end
      if (complete) begin
        if (mem_rd) begin
          rsp_valid    <= 1'b1;
          rsp_data     <= mem_dout;
          bypass_valid <= 1'b1;
          bypass_addr  <= mem_addr;
          bypass_data  <= mem_dout;
        end else begin
          wr_done <= 1'b1;
        end
        mem_rd <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule
